// File: rtl/not_not_judge.sv
`default_nettype none
// ============================================================================
// Module   : not_not_judge
// Brief    : Round sequencer and answer judge for the NOT-NOT reaction game.
// Revision : 1.0
// ============================================================================
module not_not_judge #(
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic [3:0] expected,
  input  logic       done_draw,
  output logic       lfsr_step,
  output logic       draw_req,
  output logic       draw_lose,
  output logic       lose,
  output logic [7:0] score,
  output logic [7:0] highscore,
  output logic [2:0] state_dbg
);

  localparam int              C_TW         = 27;
  localparam logic [C_TW-1:0] C_TIMER_LOAD = C_TW'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_STEP      = 3'd1,
    S_DRAW      = 3'd2,
    S_WAIT      = 3'd3,
    S_WIN       = 3'd4,
    S_LOSE      = 3'd5,
    S_LOSE_DRAW = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [3:0]      r_prev;
  logic [3:0]      r_exp;
  logic [C_TW-1:0] r_timer;
  logic            r_lose_drawn;
  logic [7:0]      r_score;
  logic [7:0]      r_high;

  logic [3:0]      w_press;
  logic            w_press_any;
  logic            w_one_hot;
  logic            w_hit;

  // Keys are active-low, so a press is a falling edge of the synchronised bit.
  assign w_press     = r_prev & ~r_sync2;
  assign w_press_any = |w_press;
  assign w_one_hot   = w_press_any && ((w_press & (w_press - 4'd1)) == 4'd0);
  assign w_hit       = w_one_hot && ((w_press & r_exp) != 4'd0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_press_any) w_next = S_STEP;
      S_STEP:      w_next = S_DRAW;
      S_DRAW:      if (done_draw) w_next = S_WAIT;
      S_WAIT: begin
        if (w_press_any)
          w_next = w_hit ? S_WIN : S_LOSE;
        else if (r_timer == '0)
          w_next = (r_exp == 4'd0) ? S_WIN : S_LOSE;
      end
      S_WIN:       w_next = S_STEP;
      S_LOSE: begin
        if (!r_lose_drawn)
          w_next = S_LOSE_DRAW;
        else if (w_press_any)
          w_next = S_IDLE;
      end
      S_LOSE_DRAW: if (done_draw) w_next = S_LOSE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1      <= 4'hF;
      r_sync2      <= 4'hF;
      r_prev       <= 4'hF;
      r_exp        <= 4'd0;
      r_timer      <= '0;
      r_lose_drawn <= 1'b0;
      r_score      <= 8'd0;
      r_high       <= 8'd0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;

      if (r_state == S_DRAW && done_draw) begin
        r_exp   <= expected;
        r_timer <= C_TIMER_LOAD;
      end else if (r_state == S_WAIT && r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end

      if (r_state == S_IDLE && w_next == S_STEP)
        r_score <= 8'd0;
      else if (r_state == S_WIN && r_score != 8'hFF)
        r_score <= r_score + 8'd1;

      if (r_state == S_WAIT && w_next == S_LOSE && r_score > r_high)
        r_high <= r_score;

      // Tracks whether the current LOSE visit has already shown its screen.
      if (r_state == S_WAIT)
        r_lose_drawn <= 1'b0;
      else if (r_state == S_LOSE_DRAW && done_draw)
        r_lose_drawn <= 1'b1;
    end
  end

  assign lfsr_step = (r_state == S_STEP);
  assign draw_req  = (r_state == S_DRAW);
  assign draw_lose = (r_state == S_LOSE_DRAW);
  assign lose      = (r_state == S_LOSE) || (r_state == S_LOSE_DRAW);
  assign score     = r_score;
  assign highscore = r_high;
  assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_not_not_judge.sv
`default_nettype none
// Scoreboarded directed bench for not_not_judge with a 16-cycle answer window.
module tb_not_not_judge;

  logic       clock     = 1'b0;
  logic       reset     = 1'b1;
  logic [3:0] key_n     = 4'hF;
  logic [3:0] expected  = 4'd0;
  logic       done_draw = 1'b0;
  logic       lfsr_step;
  logic       draw_req;
  logic       draw_lose;
  logic       lose;
  logic [7:0] score;
  logic [7:0] highscore;
  logic [2:0] state_dbg;

  not_not_judge #(.TIMEOUT_CYCLES(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .key_n     (key_n),
    .expected  (expected),
    .done_draw (done_draw),
    .lfsr_step (lfsr_step),
    .draw_req  (draw_req),
    .draw_lose (draw_lose),
    .lose      (lose),
    .score     (score),
    .highscore (highscore),
    .state_dbg (state_dbg)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] score;
    logic [7:0] high;
  } ev_t;

  ev_t        sb[$];
  ev_t        mon_exp;
  logic [2:0] mon_prev = 3'd0;
  int         errors   = 0;
  int         checks   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [7:0] s, input logic [7:0] h);
    ev_t e;
    e.kind  = k;
    e.score = s;
    e.high  = h;
    sb.push_back(e);
  endtask

  // Monitor: every lfsr_step pulse and every WAIT->LOSE entry is one response.
  always @(negedge clock) begin
    if (reset) begin
      mon_prev = 3'd0;
    end else begin
      if (lfsr_step || (state_dbg == 3'd5 && mon_prev == 3'd3)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: state %0d score %0d high %0d", state_dbg, score, highscore);
        end else begin
          mon_exp = sb.pop_front();
          check("ev_kind",  state_dbg, mon_exp.kind);
          check("ev_score", score,     mon_exp.score);
          check("ev_high",  highscore, mon_exp.high);
        end
      end
      mon_prev = state_dbg;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n = 0;
    while (state_dbg !== s && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (state_dbg !== s) check(name, state_dbg, s);
  endtask

  task automatic press(input logic [3:0] mask);
    key_n = ~mask;
    tick(3);
    key_n = 4'hF;
    tick(3);
  endtask

  // Returns on the negedge right after the edge that sampled done_draw.
  task automatic do_draw(input logic [3:0] exp);
    wait_state(3'd2, "wait_draw");
    expected  = exp;
    done_draw = 1'b1;
    tick(1);
    done_draw = 1'b0;
  endtask

  task automatic lose_and_restart(input logic [7:0] held, input logic [7:0] hs);
    wait_state(3'd6, "wait_lose_draw");
    check("lose_draw_lose",    lose,      1);
    check("lose_draw_drawlose", draw_lose, 1);
    done_draw = 1'b1;
    tick(1);
    done_draw = 1'b0;
    check("lose_state", state_dbg, 5);
    check("lose_flag",  lose,      1);
    press(4'b0001);
    check("back_idle",   state_dbg, 0);
    check("score_held",  score,     held);
    push(3'd1, 8'd0, hs);
    press(4'b0001);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("rst_state",     state_dbg, 0);
    check("rst_score",     score,     0);
    check("rst_high",      highscore, 0);
    check("rst_lfsr_step", lfsr_step, 0);
    check("rst_draw_req",  draw_req,  0);
    check("rst_draw_lose", draw_lose, 0);
    check("rst_lose",      lose,      0);
    reset = 1'b0;
    tick(3);

    // Start a game, win one round with the single correct key.
    push(3'd1, 8'd0, 8'd0);
    press(4'b0001);
    do_draw(4'b0100);
    push(3'd1, 8'd1, 8'd0);
    press(4'b0100);
    wait_state(3'd2, "redraw");
    check("redraw_score", score,    1);
    check("redraw_req",   draw_req, 1);

    // Wrong key loses; highscore takes the score.
    do_draw(4'b0100);
    push(3'd5, 8'd1, 8'd1);
    press(4'b0010);
    lose_and_restart(8'd1, 8'd1);

    // Two wins, then two keys at once loses.
    do_draw(4'b0100);
    push(3'd1, 8'd1, 8'd1);
    press(4'b0100);
    do_draw(4'b0100);
    push(3'd1, 8'd2, 8'd1);
    press(4'b0100);
    do_draw(4'b0100);
    push(3'd5, 8'd2, 8'd2);
    press(4'b0101);
    lose_and_restart(8'd2, 8'd2);

    // Empty expected set: timeout wins after exactly 16 WAIT cycles.
    do_draw(4'b0000);
    push(3'd1, 8'd1, 8'd2);
    tick(15);
    check("empty_still_wait", state_dbg, 3);
    tick(1);
    check("empty_timeout_win", state_dbg, 4);

    // Empty expected set: any press loses; lower score leaves highscore.
    do_draw(4'b0000);
    push(3'd5, 8'd1, 8'd2);
    press(4'b1000);
    lose_and_restart(8'd1, 8'd2);

    // Correct press landing exactly on the timer=0 cycle wins.
    do_draw(4'b1000);
    push(3'd1, 8'd1, 8'd2);
    tick(13);
    key_n = ~4'b1000;
    tick(2);
    check("t0_still_wait", state_dbg, 3);
    tick(1);
    check("t0_press_win", state_dbg, 4);
    key_n = 4'hF;
    tick(3);

    // Live expected changes after the draw; the latched value judges.
    do_draw(4'b1000);
    expected = 4'b0001;
    push(3'd1, 8'd2, 8'd2);
    press(4'b1000);

    // Press one cycle too late: timeout loses first.
    do_draw(4'b1000);
    push(3'd5, 8'd2, 8'd2);
    tick(14);
    key_n = ~4'b1000;
    tick(1);
    check("late_still_wait", state_dbg, 3);
    tick(1);
    check("late_timeout_lose", state_dbg, 5);
    key_n = 4'hF;
    lose_and_restart(8'd2, 8'd2);

    // 256 timeout wins: score saturates at 255.
    for (int i = 0; i < 256; i++) begin
      do_draw(4'b0000);
      push(3'd1, (i < 255) ? 8'(i + 1) : 8'd255, 8'd2);
    end
    wait_state(3'd2, "sat_draw");
    check("sat_score", score, 255);
    do_draw(4'b0000);
    push(3'd5, 8'd255, 8'd255);
    press(4'b0001);
    lose_and_restart(8'd255, 8'd255);

    // Reset while a redraw is requested.
    wait_state(3'd2, "rst_draw");
    check("pre_rst_draw_req", draw_req, 1);
    reset = 1'b1;
    #1;
    check("rst_now_state", state_dbg, 0);
    tick(1);
    check("rst_draw_req_off", draw_req,  0);
    check("rst_state_idle",   state_dbg, 0);
    check("rst_score_clr",    score,     0);
    check("rst_high_clr",     highscore, 0);
    reset = 1'b0;
    tick(3);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
